// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
// Start/busy/done handshake plus operand and result bus for the bit-serial
// adder controller.
//   master : drives start/op1/op2/ci, observes busy/done/res/co
//   slave  : the adder controller side
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             co;

    modport master (output start, op1, op2, ci, input busy, done, res, co);
    modport slave  (input start, op1, op2, ci, output busy, done, res, co);
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder: captures two operands and a carry-in on an
// accepted start, adds one bit pair per cycle LSB-first through a single
// full-adder cell (two half adders + OR), and publishes {co,res} with a
// one-cycle done pulse.
// Ports:
//   clk_i   rising-edge clock
//   rst_i   synchronous, active-high reset
//   bus     slave modport: start/op1/op2/ci in, busy/done/res/co out
// ---------------------------------------------------------------------------
module sac_half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    serial_adder_ctrl_if.slave bus
);
    // One extra bit so the counter never wraps inside a run.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d, res_q, res_d;
    logic             carry_q, carry_d, co_q, co_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Full-adder cell on the current LSB pair and the registered carry.
    logic ha0_s, ha0_c, ha1_s, ha1_c, fa_s, fa_c;

    sac_half_adder u_ha0 (.a_i(a_q[0]), .b_i(b_q[0]),  .s_o(ha0_s), .c_o(ha0_c));
    sac_half_adder u_ha1 (.a_i(ha0_s),  .b_i(carry_q), .s_o(ha1_s), .c_o(ha1_c));

    assign fa_s = ha1_s;
    assign fa_c = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        res_d   = res_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        case (state_q)
            // DONE accepts a new start just like IDLE, giving back-to-back runs.
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.op1;
                    b_d     = bus.op2;
                    carry_d = bus.ci;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                // Last bit: publish the shifted-in sum and the final carry.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    res_d   = {fa_s, sum_q[WIDTH-1:1]};
                    co_d    = fa_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.res  = res_q;
    assign bus.co   = co_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(8))  if8 ();
    serial_adder_ctrl_if #(.WIDTH(16)) if16 ();

    serial_adder_ctrl #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_i(rst), .bus(if8.slave));
    serial_adder_ctrl #(.WIDTH(16)) u_dut16 (.clk_i(clk), .rst_i(rst), .bus(if16.slave));

    int n_chk  = 0;
    int n_fail = 0;

    // Expected held result of the 8-bit DUT between runs.
    logic [7:0] m_res;
    logic       m_co;

    typedef struct {
        logic [7:0] op1;
        logic [7:0] op2;
        logic       ci;
        logic [7:0] res;
        logic       co;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Issue one 8-bit operation and return in the done cycle. During the
    // run, busy must be high, done low, and res/co must hold the previous result.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] er, input logic ec, input string nm);
        int bad;
        if8.start = 1'b1;
        if8.op1   = a;
        if8.op2   = b;
        if8.ci    = c;
        step();
        if8.start = 1'b0;
        if8.op1   = 8'($urandom);
        if8.op2   = 8'($urandom);
        if8.ci    = 1'($urandom);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (if8.busy !== 1'b1 || if8.done !== 1'b0 ||
                if8.res !== m_res || if8.co !== m_co) bad++;
            step();
        end
        chk({nm, "_runwin"}, bad, 0);
        chk({nm, "_done"}, if8.done, 1);
        chk({nm, "_busy_at_done"}, if8.busy, 0);
        chk({nm, "_res"}, if8.res, er);
        chk({nm, "_co"}, if8.co, ec);
        m_res = er;
        m_co  = ec;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s;
        int          lat;
        s = {1'b0, a} + {1'b0, b} + 17'(c);
        if16.start = 1'b1;
        if16.op1   = a;
        if16.op2   = b;
        if16.ci    = c;
        step();
        if16.start = 1'b0;
        if16.op1   = 16'($urandom);
        if16.op2   = 16'($urandom);
        lat = 1;
        while (if16.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("w16_latency", lat, 17);
        chk("w16_res", if16.res, s[15:0]);
        chk("w16_co", if16.co, s[16]);
        step();
    endtask

    initial begin
        int          ndone, at;
        logic [7:0]  r, a, b;
        logic        cy, c;
        logic [8:0]  s9;

        tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        tbl[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        tbl[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        tbl[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        rst = 1'b1;
        if8.start  = 1'b0; if8.op1  = '0; if8.op2  = '0; if8.ci  = 1'b0;
        if16.start = 1'b0; if16.op1 = '0; if16.op2 = '0; if16.ci = 1'b0;
        step();
        step();
        chk("rst_busy", if8.busy, 0);
        chk("rst_done", if8.done, 0);
        chk("rst_res", if8.res, 0);
        chk("rst_co", if8.co, 0);
        rst = 1'b0;
        m_res = 8'h00;
        m_co  = 1'b0;
        step();

        // Table vectors, each followed by a check that done is a single pulse.
        for (int i = 0; i < 8; i++) begin
            run8(tbl[i].op1, tbl[i].op2, tbl[i].ci, tbl[i].res, tbl[i].co,
                 $sformatf("vec%0d", i));
            step();
            chk($sformatf("vec%0d_pulse", i), if8.done, 0);
        end

        // Start pulsed during an active run is ignored.
        if8.start = 1'b1; if8.op1 = 8'h10; if8.op2 = 8'h20; if8.ci = 1'b0;
        step();
        if8.start = 1'b0;
        step();
        step();
        if8.start = 1'b1; if8.op1 = 8'h01; if8.op2 = 8'h01;
        step();
        if8.start = 1'b0;
        ndone = 0; at = -1; r = 8'hEE; cy = 1'bx;
        for (int i = 0; i < 12; i++) begin
            if (if8.done === 1'b1) begin
                ndone++;
                at = i;
                r  = if8.res;
                cy = if8.co;
            end
            step();
        end
        chk("busy_start_ndone", ndone, 1);
        chk("busy_start_lat", at, 5);
        chk("busy_start_res", r, 8'h30);
        chk("busy_start_co", cy, 0);
        m_res = 8'h30;
        m_co  = 1'b0;

        // Reset in the fourth RUN cycle aborts the run and clears the result.
        if8.start = 1'b1; if8.op1 = 8'h44; if8.op2 = 8'h22; if8.ci = 1'b0;
        step();
        if8.start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", if8.busy, 0);
        chk("abort_res", if8.res, 0);
        chk("abort_co", if8.co, 0);
        m_res = 8'h00;
        m_co  = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (if8.done === 1'b1) ndone++;
            step();
        end
        chk("abort_nodone", ndone, 0);
        run8(8'h3C, 8'hC4, 1'b1, 8'h01, 1'b1, "after_abort");
        step();

        // Back-to-back: start held in the DONE cycle; first result held during the second run.
        run8(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "b2b_first");
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "b2b_second");
        step();
        chk("b2b_pulse", if8.done, 0);

        for (int i = 0; i < 500; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            c  = 1'($urandom);
            s9 = {1'b0, a} + {1'b0, b} + 9'(c);
            run8(a, b, c, s9[7:0], s9[8], "rnd8");
            step();
        end

        for (int i = 0; i < 500; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        run16(16'hFFFF, 16'h0000, 1'b1);
        run16(16'hFFFF, 16'hFFFF, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
